pixel_threshold: RTL and testbench

- Per-pixel 8-bit thresholding stage in the vision/navigation pipeline.
- Takes one grayscale pixel per clock and emits one registered output pixel per clock.
- Output is either a binary mask or a to-zero result, selected by a mode bit.
- Sits between pixel capture/filtering and downstream feature extraction.

---
 rtl/pixel_threshold_pkg.sv | 17 +
 rtl/pixel_running_mean.sv | 60 ++++++
 rtl/pixel_threshold.sv | 67 ++++++
 tb/tb_pixel_threshold.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pixel_threshold_pkg.sv
// pixel_threshold_pkg: shared constants and types for the pixel thresholding stage.
// The top module is configured by the ADAPTIVE_THRESH_EN macro.
// When it is defined, the threshold tracks a running mean of the pixel stream.
package pixel_threshold_pkg;

  localparam int         PIX_W_DEF     = 8;
  localparam logic [7:0] THRESHOLD_DEF = 8'h10;

  localparam logic MODE_BINARY = 1'b0;
  localparam logic MODE_TOZERO = 1'b1;

  localparam logic [7:0] PIX_MAX = 8'hFF;
  localparam logic [7:0] PIX_MIN = 8'h00;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

endpackage

// File: rtl/pixel_running_mean.sv
// pixel_running_mean: exponential running mean of the pixel stream.
// It produces a saturated adaptive threshold, thr = sat(mean + AVG_OFFSET).
// thr is taken from the registered accumulator, so a pixel is always compared
// against the mean as it stood before that pixel was folded in.
module pixel_running_mean
  import pixel_threshold_pkg::*;
#(
  parameter int               PIX_W      = PIX_W_DEF,
  parameter logic [PIX_W-1:0] THRESHOLD  = THRESHOLD_DEF,
  parameter int               AVG_SHIFT  = 3,
  parameter logic [PIX_W-1:0] AVG_OFFSET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] in_pix,
  output logic [PIX_W-1:0] thr
);

  localparam int ACC_W = PIX_W + AVG_SHIFT;

  localparam logic [ACC_W-1:0] ACC_RESET = ACC_W'(THRESHOLD) << AVG_SHIFT;

  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_d;
  logic [PIX_W-1:0]         mean;
  logic signed [PIX_W+1:0]  thr_sum;
  logic signed [PIX_W+1:0]  offset_ext;

  // Next accumulator value: add the new pixel and leak 1/2^AVG_SHIFT of the old value.
  // The result is bounded by the accumulator width.
  // Intermediate wrap-around therefore cancels out in modular arithmetic.
  always_comb begin
    acc_d = acc_q + ACC_W'(in_pix) - (acc_q >> AVG_SHIFT);
  end

  // Mean plus signed offset, clamped to the legal pixel range.
  always_comb begin
    mean       = acc_q[ACC_W-1:AVG_SHIFT];
    offset_ext = {{2{AVG_OFFSET[PIX_W-1]}}, AVG_OFFSET};
    thr_sum    = $signed({2'b00, mean}) + offset_ext;
    if (thr_sum < 0) begin
      thr = '0;
    end else if (thr_sum > $signed({2'b00, {PIX_W{1'b1}}})) begin
      thr = {PIX_W{1'b1}};
    end else begin
      thr = thr_sum[PIX_W-1:0];
    end
  end

  // Accumulator register.
  // Reset preloads it so the threshold starts at THRESHOLD + AVG_OFFSET.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= ACC_RESET;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pixel_threshold.sv
// pixel_threshold: one-pixel-per-clock threshold stage with a 1-cycle registered output.
// When mode = 0, the output is a binary mask (0x00 or all-ones).
// When mode = 1, the output is to-zero: a passing pixel keeps its value, otherwise 0.
// Macro ADAPTIVE_THRESH_EN: when defined, the threshold comes from pixel_running_mean.
// Otherwise the threshold is the constant THRESHOLD and no accumulator exists.
module pixel_threshold
  import pixel_threshold_pkg::*;
#(
  parameter int               PIX_W      = PIX_W_DEF,
  parameter logic [PIX_W-1:0] THRESHOLD  = THRESHOLD_DEF,
  parameter int               AVG_SHIFT  = 3,
  parameter logic [PIX_W-1:0] AVG_OFFSET = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [PIX_W-1:0] in,
  output logic [PIX_W-1:0] out
);

  logic [PIX_W-1:0] thr;
  logic             pass;
  logic [PIX_W-1:0] out_d;
  logic [PIX_W-1:0] out_q;

  // Reject configurations that the accumulator sizing cannot represent.
  if (AVG_SHIFT < 1 || $bits(AVG_OFFSET) != PIX_W) begin : g_bad_cfg
    $error("pixel_threshold: unsupported AVG_SHIFT/AVG_OFFSET configuration");
  end

`ifdef ADAPTIVE_THRESH_EN
  pixel_running_mean #(
    .PIX_W      (PIX_W),
    .THRESHOLD  (THRESHOLD),
    .AVG_SHIFT  (AVG_SHIFT),
    .AVG_OFFSET (AVG_OFFSET)
  ) u_mean (
    .clk    (clk),
    .rst    (rst),
    .in_pix (in),
    .thr    (thr)
  );
`else
  assign thr = THRESHOLD;
`endif

  // Compare the pixel against the threshold and select the output for the current mode.
  always_comb begin
    pass  = (in >= thr);
    out_d = '0;
    if (pass) begin
      out_d = (mode == MODE_TOZERO) ? in : {PIX_W{1'b1}};
    end
  end

  // Output register. Reset clears it regardless of in and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_pixel_threshold.sv
// tb_pixel_threshold: directed plus randomized bench for pixel_threshold.
// A second instance is built with THRESHOLD = 0.
// Both instances are compared against a behavioural reference model.
module tb_pixel_threshold;

  localparam int AVG_SHIFT = 3;

  logic       clk;
  logic       rst;
  logic       mode;
  logic [7:0] in;
  logic [7:0] out;
  logic [7:0] out_zero;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: one running accumulator per instance.
  // This is used only when the adaptive build is enabled.
  int unsigned ref_acc [2];
  int unsigned ref_base[2] = '{32'h10, 32'h00};
  logic [7:0]  exp_out [2];

  pixel_threshold #(.THRESHOLD(8'h10)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .in   (in),
    .out  (out)
  );

  pixel_threshold #(.THRESHOLD(8'h00)) dut_zero (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .in   (in),
    .out  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Threshold in force for instance k, computed from the spec's rules.
  function automatic int refThr(input int k);
`ifdef ADAPTIVE_THRESH_EN
    int m;
    m = int'(ref_acc[k]) / (1 << AVG_SHIFT);
    if (m > 255) m = 255;
    if (m < 0)   m = 0;
    return m;
`else
    return int'(ref_base[k]);
`endif
  endfunction

  // Expected output for a pixel sampled with a given mode against threshold t.
  function automatic logic [7:0] refPixel(input int pix, input logic md, input int t);
    if (pix < t) return 8'h00;
    return md ? 8'(pix) : 8'hFF;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // Drive one edge's worth of inputs, advance the model, and check both outputs.
  task automatic applyStimulus(input string tag, input logic r, input logic md,
                               input logic [7:0] pix);
    @(negedge clk);
    rst  = r;
    mode = md;
    in   = pix;
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        exp_out[k] = 8'h00;
        ref_acc[k] = ref_base[k] * (1 << AVG_SHIFT);
      end else begin
        exp_out[k] = refPixel(int'(pix), md, refThr(k));
        ref_acc[k] = ref_acc[k] + pix - ref_acc[k] / (1 << AVG_SHIFT);
      end
    end
    @(posedge clk);
    #1;
    checkOutput(tag, out, exp_out[0]);
    checkOutput({tag, "_thr0"}, out_zero, exp_out[1]);
  endtask

  initial begin
    logic [7:0] sweep1 [3] = '{8'h0F, 8'h10, 8'h50};
    logic [7:0] sweep0 [5] = '{8'h08, 8'h25, 8'h05, 8'h50, 8'h88};
    logic [7:0] pick   [6] = '{8'h00, 8'h0F, 8'h10, 8'h11, 8'hFF, 8'h80};
    logic [7:0] pix;
    rst  = 1'b1;
    mode = 1'b1;
    in   = 8'hAA;
    ref_acc[0] = 32'h10 << AVG_SHIFT;
    ref_acc[1] = 32'h00;

    applyStimulus("reset_a", 1'b1, 1'b1, 8'hAA);
    applyStimulus("reset_b", 1'b1, 1'b1, 8'hAA);
    checkOutput("reset_const", out, 8'h00);
    applyStimulus("post_reset", 1'b0, 1'b1, 8'hAA);
    checkOutput("post_reset_const", out, 8'hAA);

    foreach (sweep1[i]) applyStimulus($sformatf("mode1_%02h", sweep1[i]), 1'b0, 1'b1, sweep1[i]);
    foreach (sweep0[i]) applyStimulus($sformatf("mode0_%02h", sweep0[i]), 1'b0, 1'b0, sweep0[i]);

    for (int i = 0; i < 8; i++) applyStimulus("toggle", 1'b0, 1'(i % 2), 8'h88);

    applyStimulus("ext_00_m0", 1'b0, 1'b0, 8'h00);
    applyStimulus("ext_00_m1", 1'b0, 1'b1, 8'h00);
    applyStimulus("ext_ff_m0", 1'b0, 1'b0, 8'hFF);
    applyStimulus("ext_ff_m1", 1'b0, 1'b1, 8'hFF);

    for (int i = 0; i < 400; i++) begin
      pix = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 5)] : 8'($urandom);
      applyStimulus("random", ($urandom_range(0, 29) == 0), 1'($urandom), pix);
    end

`ifdef ADAPTIVE_THRESH_EN
    for (int i = 0; i < 64; i++) applyStimulus("adapt_hold", 1'b0, 1'b0, 8'h80);
    applyStimulus("adapt_70", 1'b0, 1'b0, 8'h70);
    checkOutput("adapt_70_const", out, 8'h00);
    applyStimulus("adapt_90", 1'b0, 1'b0, 8'h90);
    checkOutput("adapt_90_const", out, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
